dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (CPU) has priority, port 1 (DMA/debug) gets anti-starvation and locked bursts.
// Grants/address/data are combinational (0 cycles); rvalid one cycle later; denied requesters simply wait (cpu_stall).
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic        lock1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [31:0] q_dmem,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        cpu_stall,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    output logic        wren
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] COOL  = 2'd2;

    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    logic [1:0]    state, state_nxt;
    logic [SW-1:0] starve;
    logic [BW-1:0] burst_cnt, burst_nxt;

    // Grants are forced low while reset is held so nothing reaches memory.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state)
                BURST: begin
                    if (req1)      gnt1 = 1'b1;
                    else if (req0) gnt0 = 1'b1;
                end
                COOL: gnt0 = req0;
                default: begin
                    if (req1 && starve == STARVE_TOP) gnt1 = 1'b1;
                    else if (req0)                    gnt0 = 1'b1;
                    else if (req1)                    gnt1 = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            ARB: begin
                if (gnt1 && lock1) begin
                    state_nxt = BURST;
                    burst_nxt = BW'(1);
                end
            end
            BURST: begin
                if (!req1 || !lock1) begin
                    state_nxt = ARB;
                    burst_nxt = '0;
                end else begin
                    // Saturate so an idle port 0 lets the burst run on indefinitely.
                    if (burst_cnt != BURST_TOP) burst_nxt = burst_cnt + 1'b1;
                    if (req0 && burst_nxt == BURST_TOP) begin
                        state_nxt = COOL;
                        burst_nxt = '0;
                    end
                end
            end
            COOL: begin
                state_nxt = ARB;
                burst_nxt = '0;
            end
            default: begin
                state_nxt = ARB;
                burst_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            burst_cnt <= '0;
            starve    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            // Only COOL can deny port 1 at the limit, so hold there rather than wrap.
            if (req1 && !gnt1)
                starve <= (starve == STARVE_TOP) ? starve : starve + 1'b1;
            else
                starve <= '0;
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
        end
    end

    assign rdata        = q_dmem;
    assign cpu_stall    = req0 && !gnt0;
    assign address_dmem = gnt0 ? addr0 : (gnt1 ? addr1 : 32'h0);
    assign data         = gnt0 ? wdata0 : (gnt1 ? wdata1 : 32'h0);
    assign wren         = (gnt0 && we0) || (gnt1 && we1);

endmodule
